// File: rtl/traffic_pkg.sv
// Shared aspect encodings, fault codes and monitor state for the signal conflict monitor.
// Optional stuck-phase checking is enabled by defining CONFLICT_MON_STUCK_CHECK_EN.
package traffic_pkg;

    localparam logic [2:0] LIGHT_RED    = 3'b100;
    localparam logic [2:0] LIGHT_YELLOW = 3'b010;
    localparam logic [2:0] LIGHT_GREEN  = 3'b001;
    localparam logic [2:0] LIGHT_OFF    = 3'b000;

    localparam logic [2:0] FC_NONE     = 3'd0;
    localparam logic [2:0] FC_INVALID  = 3'd1;
    localparam logic [2:0] FC_CONFLICT = 3'd2;
    localparam logic [2:0] FC_SEQUENCE = 3'd3;
    localparam logic [2:0] FC_STUCK    = 3'd4;

    typedef enum logic [1:0] {
        ST_STARTUP = 2'd0,
        ST_NORMAL  = 2'd1,
        ST_FAULT   = 2'd2
    } monitor_state_t;

    function automatic logic is_one_hot(input logic [2:0] aspect);
        return (aspect == LIGHT_RED) || (aspect == LIGHT_YELLOW) || (aspect == LIGHT_GREEN);
    endfunction

endpackage

// File: rtl/approach_tracker.sv
// Per-approach history: previous aspect, yellow dwell and (with CONFLICT_MON_STUCK_CHECK_EN)
// the non-red run length. Flags illegal transitions into red and over-long phases.
module approach_tracker
    import traffic_pkg::*;
#(
    parameter int MIN_YELLOW = 3,
    parameter int MAX_PHASE  = 60
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       i_en,
    input  logic [2:0] i_aspect,
    output logic       o_seq_err,
    output logic       o_stuck_err
);

    localparam int YW = $clog2(MIN_YELLOW + 1);
    localparam logic [YW-1:0] Y_SAT = YW'(MIN_YELLOW);

    logic [2:0]    r_prev;
    logic [YW-1:0] r_ycnt;

    // While disabled the tracker looks as if the approach has been red forever.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_prev <= LIGHT_RED;
            r_ycnt <= '0;
        end else if (!i_en) begin
            r_prev <= LIGHT_RED;
            r_ycnt <= '0;
        end else begin
            r_prev <= i_aspect;
            if (i_aspect == LIGHT_RED) begin
                r_ycnt <= '0;
            end else if ((i_aspect == LIGHT_YELLOW) && (r_ycnt != Y_SAT)) begin
                r_ycnt <= r_ycnt + 1'b1;
            end
        end
    end

    assign o_seq_err = (i_aspect == LIGHT_RED) &&
                       ((r_prev == LIGHT_GREEN) ||
                        ((r_prev == LIGHT_YELLOW) && (r_ycnt < Y_SAT)));

`ifdef CONFLICT_MON_STUCK_CHECK_EN
    localparam int NW = $clog2(MAX_PHASE + 2);
    localparam logic [NW-1:0] N_SAT = NW'(MAX_PHASE + 1);
    localparam logic [NW-1:0] N_LIM = NW'(MAX_PHASE);

    logic [NW-1:0] r_nrcnt;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_nrcnt <= '0;
        end else if (!i_en || (i_aspect == LIGHT_RED)) begin
            r_nrcnt <= '0;
        end else if (r_nrcnt != N_SAT) begin
            r_nrcnt <= r_nrcnt + 1'b1;
        end
    end

    // The current sample would be non-red run number MAX_PHASE+1.
    assign o_stuck_err = (i_aspect != LIGHT_RED) && (r_nrcnt >= N_LIM);
`else
    assign o_stuck_err = 1'b0;
`endif

endmodule

// File: rtl/signal_conflict_monitor.sv
// Fail-safe stage between the traffic controller and the lamp drivers: registers the aspects,
// checks them, and forces flashing red on a violation. Stuck check: CONFLICT_MON_STUCK_CHECK_EN.
module signal_conflict_monitor
    import traffic_pkg::*;
#(
    parameter int STARTUP_CYCLES = 2,
    parameter int MIN_YELLOW     = 3,
    parameter int MAX_PHASE      = 60,
    parameter int FLASH_HALF     = 1
) (
    input  logic           clk,
    input  logic           rst,
    input  logic [2:0]     ns_light_in,
    input  logic [2:0]     ew_light_in,
    input  logic           clear_fault,
    output logic [2:0]     ns_lamp,
    output logic [2:0]     ew_lamp,
    output logic           fault,
    output logic [2:0]     fault_code,
    output monitor_state_t dbg_state
);

    localparam int SW = (STARTUP_CYCLES > 1) ? $clog2(STARTUP_CYCLES) : 1;
    localparam int FW = (FLASH_HALF > 1) ? $clog2(FLASH_HALF) : 1;
    localparam logic [SW-1:0] START_LAST = SW'(STARTUP_CYCLES - 1);
    localparam logic [FW-1:0] FLASH_LAST = FW'(FLASH_HALF - 1);

    monitor_state_t r_state, w_state_nxt;
    logic [2:0]     r_ns_q, r_ew_q, r_ns_lamp, r_ew_lamp, r_code;
    logic [2:0]     w_ns_lamp_nxt, w_ew_lamp_nxt, w_code_nxt, w_viol;
    logic [SW-1:0]  r_start_cnt, w_start_cnt_nxt;
    logic [FW-1:0]  r_flash_cnt, w_flash_cnt_nxt;
    logic           r_flash_red, w_flash_red_nxt;
    logic           w_trk_en, w_ns_seq, w_ew_seq, w_ns_stuck, w_ew_stuck;

    assign w_trk_en = (r_state == ST_NORMAL);

    approach_tracker #(.MIN_YELLOW(MIN_YELLOW), .MAX_PHASE(MAX_PHASE)) u_ns_trk (
        .clk(clk), .rst(rst), .i_en(w_trk_en), .i_aspect(r_ns_q),
        .o_seq_err(w_ns_seq), .o_stuck_err(w_ns_stuck)
    );

    approach_tracker #(.MIN_YELLOW(MIN_YELLOW), .MAX_PHASE(MAX_PHASE)) u_ew_trk (
        .clk(clk), .rst(rst), .i_en(w_trk_en), .i_aspect(r_ew_q),
        .o_seq_err(w_ew_seq), .o_stuck_err(w_ew_stuck)
    );

    always_comb begin
        w_viol = FC_NONE;
        if (!is_one_hot(r_ns_q) || !is_one_hot(r_ew_q)) begin
            w_viol = FC_INVALID;
        end else if ((r_ns_q != LIGHT_RED) && (r_ew_q != LIGHT_RED)) begin
            w_viol = FC_CONFLICT;
        end else if (w_ns_seq || w_ew_seq) begin
            w_viol = FC_SEQUENCE;
        end else if (w_ns_stuck || w_ew_stuck) begin
            w_viol = FC_STUCK;
        end
    end

    // Lamps are registered from the next-state logic so a bad aspect is replaced by red on the
    // same edge that detects it and never reaches the lamp drivers.
    always_comb begin
        w_state_nxt     = r_state;
        w_start_cnt_nxt = r_start_cnt;
        w_flash_cnt_nxt = r_flash_cnt;
        w_flash_red_nxt = r_flash_red;
        w_code_nxt      = r_code;
        w_ns_lamp_nxt   = LIGHT_RED;
        w_ew_lamp_nxt   = LIGHT_RED;
        case (r_state)
            ST_STARTUP: begin
                if (r_start_cnt == START_LAST) begin
                    w_state_nxt     = ST_NORMAL;
                    w_start_cnt_nxt = '0;
                end else begin
                    w_start_cnt_nxt = r_start_cnt + 1'b1;
                end
            end
            ST_NORMAL: begin
                if (w_viol != FC_NONE) begin
                    w_state_nxt     = ST_FAULT;
                    w_code_nxt      = w_viol;
                    w_flash_cnt_nxt = '0;
                    w_flash_red_nxt = 1'b1;
                end else begin
                    w_ns_lamp_nxt = r_ns_q;
                    w_ew_lamp_nxt = r_ew_q;
                end
            end
            ST_FAULT: begin
                if (clear_fault && (r_ns_q == LIGHT_RED) && (r_ew_q == LIGHT_RED)) begin
                    w_state_nxt     = ST_STARTUP;
                    w_code_nxt      = FC_NONE;
                    w_start_cnt_nxt = '0;
                end else begin
                    if (r_flash_cnt == FLASH_LAST) begin
                        w_flash_cnt_nxt = '0;
                        w_flash_red_nxt = ~r_flash_red;
                    end else begin
                        w_flash_cnt_nxt = r_flash_cnt + 1'b1;
                    end
                    w_ns_lamp_nxt = w_flash_red_nxt ? LIGHT_RED : LIGHT_OFF;
                    w_ew_lamp_nxt = w_flash_red_nxt ? LIGHT_RED : LIGHT_OFF;
                end
            end
            default: begin
                w_state_nxt = ST_STARTUP;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state     <= ST_STARTUP;
            r_ns_q      <= LIGHT_RED;
            r_ew_q      <= LIGHT_RED;
            r_ns_lamp   <= LIGHT_RED;
            r_ew_lamp   <= LIGHT_RED;
            r_code      <= FC_NONE;
            r_start_cnt <= '0;
            r_flash_cnt <= '0;
            r_flash_red <= 1'b1;
        end else begin
            r_state     <= w_state_nxt;
            r_ns_q      <= ns_light_in;
            r_ew_q      <= ew_light_in;
            r_ns_lamp   <= w_ns_lamp_nxt;
            r_ew_lamp   <= w_ew_lamp_nxt;
            r_code      <= w_code_nxt;
            r_start_cnt <= w_start_cnt_nxt;
            r_flash_cnt <= w_flash_cnt_nxt;
            r_flash_red <= w_flash_red_nxt;
        end
    end

    assign ns_lamp    = r_ns_lamp;
    assign ew_lamp    = r_ew_lamp;
    assign fault      = (r_state == ST_FAULT);
    assign fault_code = r_code;
    assign dbg_state  = r_state;

endmodule

// File: tb/tb_signal_conflict_monitor.sv
// Directed bench for signal_conflict_monitor with default parameters; the stuck-phase
// expectation follows CONFLICT_MON_STUCK_CHECK_EN.
module tb_signal_conflict_monitor;

    localparam logic [2:0] R   = 3'b100;
    localparam logic [2:0] Y   = 3'b010;
    localparam logic [2:0] G   = 3'b001;
    localparam logic [2:0] OFF = 3'b000;

    logic       clk = 1'b0;
    logic       rst;
    logic [2:0] ns_in, ew_in;
    logic       clr;
    logic [2:0] ns_lamp, ew_lamp, fault_code;
    logic       fault;
    logic [1:0] dbg_state;

    int n_vec = 0;
    int n_err = 0;

    always #5 clk = ~clk;

    signal_conflict_monitor dut (
        .clk(clk), .rst(rst),
        .ns_light_in(ns_in), .ew_light_in(ew_in), .clear_fault(clr),
        .ns_lamp(ns_lamp), .ew_lamp(ew_lamp),
        .fault(fault), .fault_code(fault_code), .dbg_state(dbg_state)
    );

    // One active edge, then settle before looking at outputs.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // From FAULT: present red/red, clear, and run through startup back to NORMAL.
    task automatic recover();
        ns_in = R; ew_in = R; clr = 1'b0;
        tick();
        clr = 1'b1;
        tick();
        clr = 1'b0;
        tick();
        tick();
    endtask

    task automatic test_reset();
        rst = 1'b0; ns_in = R; ew_in = R; clr = 1'b0;
        tick();
        tick();
        n_vec++; if ({ns_lamp, ew_lamp} !== {R, R}) begin n_err++; $display("FAIL reset_lamps: got %b/%b expected 100/100", ns_lamp, ew_lamp); end
        n_vec++; if (fault !== 1'b0) begin n_err++; $display("FAIL reset_fault: got %b expected 0", fault); end
        n_vec++; if (fault_code !== 3'd0) begin n_err++; $display("FAIL reset_code: got %0d expected 0", fault_code); end
        rst = 1'b1;
    endtask

    task automatic test_legal_cycle();
        logic [2:0] v_ns[$];
        logic [2:0] v_ew[$];
        logic [2:0] p_ns, p_ew, e_ns, e_ew;
        for (int r = 0; r < 2; r++) begin
            for (int i = 0; i < 5; i++) begin v_ns.push_back(G); v_ew.push_back(R); end
            for (int i = 0; i < 3; i++) begin v_ns.push_back(Y); v_ew.push_back(R); end
            for (int i = 0; i < 5; i++) begin v_ns.push_back(R); v_ew.push_back(G); end
            for (int i = 0; i < 3; i++) begin v_ns.push_back(R); v_ew.push_back(Y); end
        end
        v_ns.push_back(R); v_ew.push_back(R);
        v_ns.push_back(R); v_ew.push_back(R);
        p_ns = R; p_ew = R;
        for (int i = 0; i < v_ns.size(); i++) begin
            ns_in = v_ns[i]; ew_in = v_ew[i];
            tick();
            e_ns = (i < 2) ? R : p_ns;
            e_ew = (i < 2) ? R : p_ew;
            n_vec++; if (fault !== 1'b0) begin n_err++; $display("FAIL legal_fault[%0d]: got %b expected 0", i, fault); end
            n_vec++; if ({ns_lamp, ew_lamp} !== {e_ns, e_ew}) begin n_err++; $display("FAIL legal_lamps[%0d]: got %b/%b expected %b/%b", i, ns_lamp, ew_lamp, e_ns, e_ew); end
            p_ns = v_ns[i]; p_ew = v_ew[i];
        end
    endtask

    task automatic test_conflict_flash();
        ns_in = G; ew_in = G;
        tick();
        ns_in = R; ew_in = R;
        tick();
        n_vec++; if (fault !== 1'b1) begin n_err++; $display("FAIL conflict_fault: got %b expected 1", fault); end
        n_vec++; if (fault_code !== 3'd2) begin n_err++; $display("FAIL conflict_code: got %0d expected 2", fault_code); end
        n_vec++; if ({ns_lamp, ew_lamp} !== {R, R}) begin n_err++; $display("FAIL conflict_lamps_on: got %b/%b expected 100/100", ns_lamp, ew_lamp); end
        ns_in = 3'b011;
        tick();
        n_vec++; if ({ns_lamp, ew_lamp} !== {OFF, OFF}) begin n_err++; $display("FAIL flash_off: got %b/%b expected 000/000", ns_lamp, ew_lamp); end
        n_vec++; if (fault_code !== 3'd2) begin n_err++; $display("FAIL code_held: got %0d expected 2", fault_code); end
        ns_in = R;
        tick();
        n_vec++; if ({ns_lamp, ew_lamp} !== {R, R}) begin n_err++; $display("FAIL flash_on_again: got %b/%b expected 100/100", ns_lamp, ew_lamp); end
    endtask

    task automatic test_clear();
        logic [2:0] v_ns[6];
        logic [2:0] e_ns;
        ns_in = G; ew_in = R; clr = 1'b0;
        tick();
        n_vec++; if ({ns_lamp, ew_lamp} !== {OFF, OFF}) begin n_err++; $display("FAIL clear_pre_off: got %b/%b expected 000/000", ns_lamp, ew_lamp); end
        clr = 1'b1;
        tick();
        n_vec++; if (fault !== 1'b1) begin n_err++; $display("FAIL clear_ignored_fault: got %b expected 1", fault); end
        n_vec++; if (fault_code !== 3'd2) begin n_err++; $display("FAIL clear_ignored_code: got %0d expected 2", fault_code); end
        n_vec++; if ({ns_lamp, ew_lamp} !== {R, R}) begin n_err++; $display("FAIL clear_ignored_lamps: got %b/%b expected 100/100", ns_lamp, ew_lamp); end
        ns_in = R;
        tick();
        n_vec++; if ({fault, ns_lamp} !== {1'b1, OFF}) begin n_err++; $display("FAIL clear_still_flash: got %b/%b expected 1/000", fault, ns_lamp); end
        tick();
        n_vec++; if (fault !== 1'b0) begin n_err++; $display("FAIL clear_fault: got %b expected 0", fault); end
        n_vec++; if (fault_code !== 3'd0) begin n_err++; $display("FAIL clear_code: got %0d expected 0", fault_code); end
        n_vec++; if ({ns_lamp, ew_lamp} !== {R, R}) begin n_err++; $display("FAIL clear_lamps: got %b/%b expected 100/100", ns_lamp, ew_lamp); end
        clr = 1'b0;
        v_ns = '{Y, Y, Y, Y, R, R};
        for (int i = 0; i < 6; i++) begin
            ns_in = v_ns[i]; ew_in = R;
            tick();
            e_ns = (i < 2) ? R : v_ns[i-1];
            n_vec++; if (fault !== 1'b0) begin n_err++; $display("FAIL restart_fault[%0d]: got %b expected 0", i, fault); end
            n_vec++; if ({ns_lamp, ew_lamp} !== {e_ns, R}) begin n_err++; $display("FAIL restart_lamps[%0d]: got %b/%b expected %b/100", i, ns_lamp, ew_lamp, e_ns); end
        end
    endtask

    task automatic test_short_yellow();
        logic [2:0] v_ns[4];
        v_ns = '{Y, Y, R, R};
        ew_in = R;
        for (int i = 0; i < 3; i++) begin
            ns_in = v_ns[i];
            tick();
            n_vec++; if (fault !== 1'b0) begin n_err++; $display("FAIL short_yellow_early[%0d]: got %b expected 0", i, fault); end
        end
        n_vec++; if (ns_lamp !== Y) begin n_err++; $display("FAIL short_yellow_pass: got %b expected 010", ns_lamp); end
        ns_in = v_ns[3];
        tick();
        n_vec++; if ({fault, fault_code} !== {1'b1, 3'd3}) begin n_err++; $display("FAIL short_yellow_code: got %b/%0d expected 1/3", fault, fault_code); end
        n_vec++; if ({ns_lamp, ew_lamp} !== {R, R}) begin n_err++; $display("FAIL short_yellow_lamps: got %b/%b expected 100/100", ns_lamp, ew_lamp); end
        recover();
    endtask

    task automatic test_priority();
        ns_in = 3'b011; ew_in = G;
        tick();
        ns_in = R; ew_in = R;
        tick();
        n_vec++; if ({fault, fault_code} !== {1'b1, 3'd1}) begin n_err++; $display("FAIL priority_code: got %b/%0d expected 1/1", fault, fault_code); end
        n_vec++; if ({ns_lamp, ew_lamp} !== {R, R}) begin n_err++; $display("FAIL priority_lamps: got %b/%b expected 100/100", ns_lamp, ew_lamp); end
        recover();
    endtask

    task automatic test_stuck();
        ns_in = G; ew_in = R;
        for (int k = 1; k <= 61; k++) begin
            tick();
            n_vec++; if (fault !== 1'b0) begin n_err++; $display("FAIL stuck_early[%0d]: got %b expected 0", k, fault); end
        end
        tick();
`ifdef CONFLICT_MON_STUCK_CHECK_EN
        n_vec++; if ({fault, fault_code} !== {1'b1, 3'd4}) begin n_err++; $display("FAIL stuck_code: got %b/%0d expected 1/4", fault, fault_code); end
        n_vec++; if ({ns_lamp, ew_lamp} !== {R, R}) begin n_err++; $display("FAIL stuck_lamps: got %b/%b expected 100/100", ns_lamp, ew_lamp); end
`else
        n_vec++; if ({fault, fault_code} !== {1'b0, 3'd0}) begin n_err++; $display("FAIL stuck_code: got %b/%0d expected 0/0", fault, fault_code); end
        n_vec++; if ({ns_lamp, ew_lamp} !== {G, R}) begin n_err++; $display("FAIL stuck_lamps: got %b/%b expected 001/100", ns_lamp, ew_lamp); end
`endif
    endtask

    task automatic test_reset_mid_flash();
        bit found = 1'b0;
        ns_in = G; ew_in = G;
        for (int k = 0; k < 6 && !found; k++) begin
            tick();
            if (fault === 1'b1 && ns_lamp === OFF) found = 1'b1;
        end
        n_vec++; if (!found) begin n_err++; $display("FAIL flash_off_reached: got no 000 phase expected one within 6 cycles"); end
        #2;
        rst = 1'b0;
        #1;
        n_vec++; if ({ns_lamp, ew_lamp} !== {R, R}) begin n_err++; $display("FAIL async_reset_lamps: got %b/%b expected 100/100", ns_lamp, ew_lamp); end
        n_vec++; if ({fault, fault_code} !== {1'b0, 3'd0}) begin n_err++; $display("FAIL async_reset_fault: got %b/%0d expected 0/0", fault, fault_code); end
        ns_in = R; ew_in = R;
        tick();
        rst = 1'b1;
    endtask

    initial begin
        test_reset();
        test_legal_cycle();
        test_conflict_flash();
        test_clear();
        test_short_yellow();
        test_priority();
        test_stuck();
        test_reset_mid_flash();
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

// File: doc/signal_conflict_monitor.md
# signal_conflict_monitor

Fail-safe stage directly downstream of `traffic_light_controller`. It registers the controller's `ns_light`/`ew_light` outputs, checks them every clock against the intersection safety rules, and passes them to the lamp drivers. On any violation it latches a fault code and overrides both approaches with flashing red until an operator clear is accepted. It runs on the same 1 Hz controller clock.

## Interface
- `STARTUP_CYCLES`, default 2: all-red cycles forced after reset or after a fault clear.
- `MIN_YELLOW`, default 3: minimum consecutive yellow samples required before red.
- `MAX_PHASE`, default 60: maximum consecutive non-red samples per approach.
- `FLASH_HALF`, default 1: cycles on and cycles off of the fault flash.
- `clk  in  1`: controller clock, rising edge.
- `rst  in  1`: asynchronous, active-low reset.
- `ns_light_in  in  3`: N/S aspect from the controller.
- `ew_light_in  in  3`: E/W aspect from the controller.
- `clear_fault  in  1`: level-sampled operator clear.
- `ns_lamp  out  3`: N/S lamp drive.
- `ew_lamp  out  3`: E/W lamp drive.
- `fault  out  1`: high while in FAULT.
- `fault_code  out  3`: latched cause of the fault; 0 when there is none.

Clock and reset are fixed: one clock, `clk`; reset is asynchronous and active-low, port name `rst`.

## Operation
- Aspect encoding, one-hot:
  - RED = 3'b100, YELLOW = 3'b010, GREEN = 3'b001.
  - Lamp-off = 3'b000, which appears on outputs only.
- Input stage: both inputs are registered once. All checks operate on the registered copies (`ns_q`, `ew_q`).
- States:
  - STARTUP: lamps all-red, checks disabled, counter increments. After `STARTUP_CYCLES` cycles go to NORMAL. Per-approach trackers are reset to "previous = RED, counts = 0".
  - NORMAL: lamps = `ns_q`/`ew_q`, checks active. Any violation goes to FAULT.
  - FAULT: `fault`=1, `fault_code` latched. Both lamps flash: RED for `FLASH_HALF` cycles, then 3'b000 for `FLASH_HALF` cycles, repeating and starting with RED.
    - If `clear_fault`=1 and `ns_q`=`ew_q`=RED on the same edge: go to STARTUP and clear `fault_code` to 0.
    - Otherwise `clear_fault` is ignored.
- Violation codes, with priority when several fire on the same edge: 1 > 2 > 3 > 4.
  - 1 INVALID: either registered aspect is not one-hot.
  - 2 CONFLICT: neither approach is RED.
  - 3 SEQUENCE: an approach goes GREEN to RED directly, or YELLOW to RED with fewer than `MIN_YELLOW` yellow samples.
  - 4 STUCK: an approach is non-RED for more than `MAX_PHASE` consecutive samples.
- Counters:
  - Yellow counter saturates at `MIN_YELLOW`; width `$clog2(MIN_YELLOW+1)`.
  - Non-red counter saturates at `MAX_PHASE+1`; width `$clog2(MAX_PHASE+2)`.
  - Both counters reset when the approach is RED.
- A RED to YELLOW transition is legal.

## Timing
- Reset values (asynchronous, applied immediately on `rst` low):
  - `ns_lamp` = `ew_lamp` = 3'b100.
  - `fault` = 0, `fault_code` = 0.
  - State = STARTUP; all counters 0.
- NORMAL latency: an input sampled at edge N appears on the lamps after edge N+1.
- Fault detection: for a bad input sampled at edge N, the check fires on `*_q` and sets `fault`/`fault_code` at edge N+1. The lamps show RED from edge N+1; the bad aspect never reaches the lamps.
- Flash phase restarts at RED on every entry to FAULT.
- A clear accepted at edge M gives `fault`=0 after edge M. STARTUP all-red lasts `STARTUP_CYCLES` cycles; lamps follow the inputs from then on.
- New violations while in FAULT do not change `fault_code`.
- Reset mid-flash or mid-STARTUP returns to the reset values immediately.

## Configuration
- `CONFLICT_MON_STUCK_CHECK_EN`:
  - Defined: code 4 is checked and the non-red counters exist.
  - Undefined: the counters are removed, code 4 is never produced, and `MAX_PHASE` is unused.

## Structure
- Package `traffic_pkg` holds:
  - Aspect constants `LIGHT_RED`, `LIGHT_YELLOW`, `LIGHT_GREEN`, `LIGHT_OFF`.
  - Fault-code constants `FC_NONE`, `FC_INVALID`, `FC_CONFLICT`, `FC_SEQUENCE`, `FC_STUCK`.
  - Monitor state enum.
- Sub-module `approach_tracker`, instantiated once per approach:
  - Holds the previous aspect, the yellow counter and the non-red counter.
  - Outputs `seq_err` and `stuck_err`.
- The top level contains the FSM, the priority encoder and the flash timer.

## Test plan
- Legal cycle after startup (GREEN 5, YELLOW 3, RED per approach, alternating) with default parameters: `fault` stays 0; lamps equal the inputs delayed by one cycle; lamps are all-red for the first 2 cycles after reset.
- `ns`=001 with `ew`=001 on one edge: one edge later `fault`=1, `fault_code`=2, lamps 100/100; lamps then show 000/000 on the next cycle and 100/100 on the one after.
- `ns` YELLOW for 2 samples then RED, `MIN_YELLOW`=3: `fault_code`=3. Separately, `ns`=011 together with a conflict on the same edge: `fault_code`=1 (priority).
- In FAULT, `clear_fault`=1 with `ns`=001: ignored, still flashing. `clear_fault`=1 with both inputs 100: `fault`=0, `fault_code`=0, 2 all-red cycles, then pass-through.
- `ns` GREEN held for 61 samples, `MAX_PHASE`=60: `fault_code`=4 with the macro defined; no fault with the macro undefined.
- `rst` driven low mid-flash while lamps are 000: lamps become 100/100 immediately (asynchronously) and `fault`=0.
